irl_limiting_profile_mem: RTL and testbench
===========================================

Name: irl_limiting_profile_mem

Overview:
- PIO-accessible limiting-profile table for the ingress rate limiter; one instance for CIR and one for EIR.
- Sits directly downstream of the IRL PIO decode. It consumes that block's one-hot select, and returns mem_ack and mem_rdata to it.
- It also serves the rate limiter datapath's per-flow profile lookups, with arbitration and a post-reset clearing sweep.

Parameters:
DEPTH, 256, number of profile entries
ADDR_NBITS, 8, entry index width (log2 DEPTH)
DATA_NBITS, 32, entry width, equals `PIO_NBITS
STARVE_LIMIT, 15, max consecutive cycles a pending PIO access may lose to lookups

Ports:
clk  in  1  core clock
`RESET_SIG  in  1  asynchronous active-low reset (rst_n)
clk_div  in  1  one-cycle PIO sample strobe, same as fed to the PIO decode
reg_ms  in  1  select from PIO decode (combinational decode of reg_addr)
reg_wr  in  1  single-cycle PIO write pulse
reg_rd  in  1  single-cycle PIO read pulse
reg_addr  in  ADDR_NBITS  entry index (low PIO address bits)
reg_din  in  DATA_NBITS  PIO write data
lookup_valid  in  1  datapath lookup request
lookup_addr  in  ADDR_NBITS  datapath entry index
lookup_ready  out  1  lookup accepted this cycle
lookup_rvalid  out  1  lookup data valid
lookup_rdata  out  DATA_NBITS  lookup data
mem_ack  out  1  PIO access complete (to PIO decode)
mem_rdata  out  DATA_NBITS  PIO read data (to PIO decode)
init_done  out  1  clearing sweep finished

Behaviour:
- Reset values:
  - All outputs 0.
  - State INIT.
  - Sweep counter 0.
  - Starvation counter 0.
- INIT state:
  - Writes 0 to entry sweep_cnt each cycle, sweep_cnt = 0..DEPTH-1; takes DEPTH cycles.
  - lookup_ready=0 throughout.
  - A PIO request arriving during INIT is latched and serviced after the sweep.
  - After the sweep: init_done=1 (sticky until reset), go to IDLE, or PEND if a request is latched.
- Request capture:
  - Any cycle with reg_ms & (reg_rd|reg_wr) latches addr, din, and wr flag.
  - Only one outstanding request exists at a time.
  - New pulses while in PEND/ACCESS/DONE are ignored.
  - reg_wr & reg_rd together is treated as a write.
- IDLE: on a captured request, go to PEND.
- PEND arbitration:
  - The lookup wins when lookup_valid=1 and starve_cnt<STARVE_LIMIT; starve_cnt increments.
  - Otherwise PIO wins: lookup_ready=0 that cycle, the array is accessed, starve_cnt clears, go to ACCESS.
  - Outside PEND: lookup_ready = init_done, and starve_cnt=0.
- ACCESS:
  - Write: entry updated in the PEND-win cycle.
  - Read: mem_rdata registered from the array, valid in ACCESS.
  - Go to DONE.
- DONE:
  - mem_ack=1 held until and including the first cycle with clk_div=1.
  - Next cycle mem_ack=0 and state returns to IDLE.
  - If clk_div=1 on DONE entry, ack is one cycle.
- mem_rdata holds until the next PIO read updates it. Writes do not alter it.
- Out-of-range index (addr>=DEPTH, non-power-of-2 DEPTH):
  - Write is dropped; read returns 0.
  - Still acked. Lookups at such an index return 0.
- Lookup latency: lookup_rvalid=1 exactly one cycle after lookup_valid & lookup_ready, with registered lookup_rdata. Back-to-back lookups give full throughput.
- A PIO write in cycle T is visible to a lookup accepted in T+1. No same-cycle collision is possible.
- Reset mid-operation: immediate abort, outputs to reset values, INIT sweep restarts.

Test Plan:
- Release reset, hold lookup_valid=1 -> lookup_ready=0 for 256 cycles, init_done=1 at cycle 256, lookups of any index return 0.
- PIO write 0x0012_3456 to index 5, then PIO read index 5, clk_div every 4th cycle -> mem_ack high through the next clk_div cycle, mem_rdata=0x0012_3456, ack drops the following cycle.
- Continuous lookup_valid with PIO write pending -> exactly 15 lookups accepted, then one cycle lookup_ready=0 and the PIO write executes, mem_ack follows.
- PIO write 0xAAAA_5555 to index 7 at cycle T, lookup index 7 at T+1 -> lookup_rvalid at T+2 with data 0xAAAA_5555.
- Second reg_rd pulse while in DONE -> ignored, single mem_ack pulse, no extra access; reg_wr with reg_ms=0 -> no capture, no ack.
- Assert reset while in PEND -> mem_ack=0, state INIT, index 5 cleared to 0 after the sweep.

Source files
------------

// File: rtl/irl_limiting_profile_mem.sv
// Limiting-profile table for the ingress rate limiter (one instance per CIR/EIR).
// PIO accesses arrive from the IRL PIO decode and share the array with the
// datapath's per-flow lookups. Lookups normally win, but a pending PIO access
// is guaranteed service after STARVE_LIMIT consecutive losses. After reset the
// whole table is swept to zero before any lookup is accepted.
`timescale 1ns/1ps

module irl_limiting_profile_mem #(
    parameter int DEPTH        = 256,
    parameter int ADDR_NBITS   = 8,
    parameter int DATA_NBITS   = 32,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_div,
    input  logic                  reg_ms,
    input  logic                  reg_wr,
    input  logic                  reg_rd,
    input  logic [ADDR_NBITS-1:0] reg_addr,
    input  logic [DATA_NBITS-1:0] reg_din,
    input  logic                  lookup_valid,
    input  logic [ADDR_NBITS-1:0] lookup_addr,
    output logic                  lookup_ready,
    output logic                  lookup_rvalid,
    output logic [DATA_NBITS-1:0] lookup_rdata,
    output logic                  mem_ack,
    output logic [DATA_NBITS-1:0] mem_rdata,
    output logic                  init_done
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_NBITS-1:0] LAST_IDX = ADDR_NBITS'(DEPTH - 1);
    localparam logic [ADDR_NBITS:0]   DEPTH_EXT = (ADDR_NBITS + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PEND,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_NBITS-1:0] sweep_cnt;
    logic [SW-1:0]         starve_cnt;

    logic                  req_pend;
    logic                  req_wr;
    logic [ADDR_NBITS-1:0] req_addr;
    logic [DATA_NBITS-1:0] req_din;

    logic                  capture;
    logic                  pio_win;
    logic                  mem_we;
    logic [ADDR_NBITS-1:0] mem_waddr;
    logic [DATA_NBITS-1:0] mem_wdata;
    logic                  req_in_range;
    logic                  lk_in_range;
    logic [DATA_NBITS-1:0] pio_rd_data;
    logic [DATA_NBITS-1:0] lk_rd_data;

    logic [DATA_NBITS-1:0] mem [DEPTH];

    // Out-of-range indices (only reachable for non-power-of-2 DEPTH) read as zero and never write.
    always_comb begin
        req_in_range = ({1'b0, req_addr} < DEPTH_EXT);
        lk_in_range  = ({1'b0, lookup_addr} < DEPTH_EXT);
        pio_rd_data  = req_in_range ? mem[req_addr] : '0;
        lk_rd_data   = lk_in_range ? mem[lookup_addr] : '0;
    end

    // Arbitration, sweep write port selection and next-state decode.
    always_comb begin
        next_state   = state;
        lookup_ready = 1'b0;
        pio_win      = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = req_addr;
        mem_wdata    = req_din;
        // Requests are only taken while nothing is outstanding; INIT holds one for later.
        capture      = reg_ms & (reg_rd | reg_wr) & ~req_pend &
                       ((state == S_INIT) | (state == S_IDLE));
        case (state)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_cnt;
                mem_wdata = '0;
                if (sweep_cnt == LAST_IDX)
                    next_state = (req_pend | capture) ? S_PEND : S_IDLE;
            end
            S_IDLE: begin
                lookup_ready = init_done;
                if (req_pend | capture)
                    next_state = S_PEND;
            end
            S_PEND: begin
                if (lookup_valid && (starve_cnt < SW'(STARVE_LIMIT))) begin
                    lookup_ready = 1'b1;
                end else begin
                    pio_win    = 1'b1;
                    mem_we     = req_wr & req_in_range;
                    next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                lookup_ready = init_done;
                next_state   = S_DONE;
            end
            S_DONE: begin
                lookup_ready = init_done;
                if (clk_div)
                    next_state = S_IDLE;
            end
            default: next_state = S_INIT;
        endcase
    end

    // Control state, request latch, PIO and lookup output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_INIT;
            sweep_cnt     <= '0;
            starve_cnt    <= '0;
            init_done     <= 1'b0;
            req_pend      <= 1'b0;
            req_wr        <= 1'b0;
            req_addr      <= '0;
            req_din       <= '0;
            mem_ack       <= 1'b0;
            mem_rdata     <= '0;
            lookup_rvalid <= 1'b0;
            lookup_rdata  <= '0;
        end else begin
            state <= next_state;
            if (state == S_INIT) begin
                sweep_cnt <= sweep_cnt + ADDR_NBITS'(1);
                if (sweep_cnt == LAST_IDX)
                    init_done <= 1'b1;
            end
            if ((state == S_PEND) && lookup_ready)
                starve_cnt <= starve_cnt + SW'(1);
            else
                starve_cnt <= '0;
            if (capture) begin
                req_pend <= 1'b1;
                req_wr   <= reg_wr;
                req_addr <= reg_addr;
                req_din  <= reg_din;
            end else if (pio_win) begin
                req_pend <= 1'b0;
            end
            if (pio_win && !req_wr)
                mem_rdata <= pio_rd_data;
            mem_ack       <= (next_state == S_DONE);
            lookup_rvalid <= lookup_valid & lookup_ready;
            if (lookup_valid && lookup_ready)
                lookup_rdata <= lk_rd_data;
        end
    end

    // Profile array: single write port shared by the clearing sweep and PIO writes.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_irl_limiting_profile_mem.sv
// Directed bench for irl_limiting_profile_mem: sweep, PIO handshake, arbitration,
// write-to-lookup visibility, ignored pulses and reset abort.
`timescale 1ns/1ps

module tb_irl_limiting_profile_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_div;
    logic        reg_ms, reg_wr, reg_rd;
    logic [7:0]  reg_addr;
    logic [31:0] reg_din;
    logic        lookup_valid;
    logic [7:0]  lookup_addr;
    logic        lookup_ready, lookup_rvalid, mem_ack, init_done;
    logic [31:0] lookup_rdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int div_mode = 1;   // 0: clk_div low, 1: clk_div high, 2: high every 4th cycle
    int bad, acc, extra;

    irl_limiting_profile_mem #(
        .DEPTH(256), .ADDR_NBITS(8), .DATA_NBITS(32), .STARVE_LIMIT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
        .reg_ms(reg_ms), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .reg_din(reg_din),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
        .lookup_ready(lookup_ready), .lookup_rvalid(lookup_rvalid),
        .lookup_rdata(lookup_rdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        case (div_mode)
            0:       clk_div = 1'b0;
            1:       clk_div = 1'b1;
            default: clk_div = ((cyc % 4) == 0);
        endcase
    endtask

    task automatic pio_pulse(input logic ms, input logic wr, input logic rd,
                             input logic [7:0] a, input logic [31:0] d);
        reg_ms = ms; reg_wr = wr; reg_rd = rd; reg_addr = a; reg_din = d;
        step();
        reg_ms = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int limit);
        int n = 0;
        while (mem_ack !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        chk({tag, "_ack_rise"}, 32'(mem_ack), 32'd1);
    endtask

    // ack must stay high until the cycle clk_div is high has been sampled, then drop
    task automatic ack_track(input string tag);
        logic d;
        wait_ack(tag, 16);
        for (int i = 0; i < 8; i++) begin
            d = clk_div;
            step();
            chk({tag, "_ack_hold"}, 32'(mem_ack), d ? 32'd0 : 32'd1);
            if (d) break;
        end
        chk({tag, "_ack_low"}, 32'(mem_ack), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; clk_div = 1'b0;
        reg_ms = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_din = '0;
        lookup_valid = 1'b1; lookup_addr = 8'd3;

        // reset state
        repeat (3) step();
        #1;
        chk("rst_ready", 32'(lookup_ready), 32'd0);
        chk("rst_ack", 32'(mem_ack), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rvalid", 32'(lookup_rvalid), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_lookup_rdata", lookup_rdata, 32'd0);

        // sweep: 256 cycles with lookups refused
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (lookup_ready !== 1'b0 || init_done !== 1'b0 || lookup_rvalid !== 1'b0) bad++;
            step();
        end
        chk("sweep_ready_low_cycles", 32'(bad), 32'd0);
        #1;
        chk("sweep_init_done", 32'(init_done), 32'd1);
        chk("sweep_ready_after", 32'(lookup_ready), 32'd1);
        lookup_addr = 8'd255;
        step();
        chk("lk255_rvalid", 32'(lookup_rvalid), 32'd1);
        chk("lk255_rdata", lookup_rdata, 32'd0);
        lookup_valid = 1'b0;
        step();
        chk("lk_rvalid_clear", 32'(lookup_rvalid), 32'd0);

        // PIO write then read of index 5 with clk_div every 4th cycle
        div_mode = 2;
        pio_pulse(1'b1, 1'b1, 1'b0, 8'd5, 32'h0012_3456);
        ack_track("wr5");
        pio_pulse(1'b1, 1'b0, 1'b1, 8'd5, 32'h0);
        ack_track("rd5");
        chk("rd5_rdata", mem_rdata, 32'h0012_3456);

        // write index 7 in cycle T, lookup index 7 accepted in T+1
        div_mode = 1;
        pio_pulse(1'b1, 1'b1, 1'b0, 8'd7, 32'hAAAA_5555);
        chk("w7_pend_ack", 32'(mem_ack), 32'd0);
        step();
        chk("w7_access_ack", 32'(mem_ack), 32'd0);
        lookup_valid = 1'b1; lookup_addr = 8'd7;
        step();
        chk("w7_done_ack", 32'(mem_ack), 32'd1);
        chk("w7_lk_rvalid", 32'(lookup_rvalid), 32'd1);
        chk("w7_lk_rdata", lookup_rdata, 32'hAAAA_5555);
        chk("w7_rdata_kept", mem_rdata, 32'h0012_3456);
        lookup_valid = 1'b0;
        step();
        chk("w7_ack_one_cycle", 32'(mem_ack), 32'd0);

        // starvation bound: 15 lookup wins, then the pending write
        lookup_valid = 1'b1; lookup_addr = 8'd5;
        pio_pulse(1'b1, 1'b1, 1'b0, 8'd9, 32'h0000_9999);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (lookup_ready !== 1'b1) break;
            acc++;
            step();
        end
        chk("starve_wins", 32'(acc), 32'd15);
        chk("starve_lk_rdata", lookup_rdata, 32'h0012_3456);
        step();
        #1;
        chk("starve_win_no_lk", 32'(lookup_rvalid), 32'd0);
        chk("starve_access_ready", 32'(lookup_ready), 32'd1);
        step();
        chk("starve_ack", 32'(mem_ack), 32'd1);
        lookup_addr = 8'd9;
        step();
        chk("starve_ack_drop", 32'(mem_ack), 32'd0);
        chk("w9_lk_rdata", lookup_rdata, 32'h0000_9999);
        lookup_valid = 1'b0;

        // second read pulse during DONE is ignored
        div_mode = 0; clk_div = 1'b0;
        pio_pulse(1'b1, 1'b0, 1'b1, 8'd5, 32'h0);
        step();
        step();
        chk("dup_first_ack", 32'(mem_ack), 32'd1);
        pio_pulse(1'b1, 1'b0, 1'b1, 8'd7, 32'h0);
        chk("dup_ack_hold", 32'(mem_ack), 32'd1);
        chk("dup_rdata", mem_rdata, 32'h0012_3456);
        div_mode = 1; clk_div = 1'b1;
        step();
        chk("dup_ack_drop", 32'(mem_ack), 32'd0);
        extra = 0;
        repeat (6) begin
            step();
            if (mem_ack !== 1'b0) extra++;
        end
        chk("dup_no_second_ack", 32'(extra), 32'd0);
        chk("dup_no_second_read", mem_rdata, 32'h0012_3456);

        // write strobe without select is not captured
        pio_pulse(1'b0, 1'b1, 1'b0, 8'd5, 32'hDEAD_BEEF);
        extra = 0;
        repeat (6) begin
            step();
            if (mem_ack !== 1'b0) extra++;
        end
        chk("nosel_no_ack", 32'(extra), 32'd0);
        lookup_valid = 1'b1; lookup_addr = 8'd5;
        step();
        chk("nosel_entry_kept", lookup_rdata, 32'h0012_3456);

        // reset while PEND aborts, sweep clears, request latched during INIT is served
        pio_pulse(1'b1, 1'b1, 1'b0, 8'd5, 32'h5555_5555);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_ack", 32'(mem_ack), 32'd0);
        chk("abort_init_done", 32'(init_done), 32'd0);
        chk("abort_ready", 32'(lookup_ready), 32'd0);
        chk("abort_rvalid", 32'(lookup_rvalid), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        pio_pulse(1'b1, 1'b1, 1'b0, 8'd6, 32'h0000_0066);
        wait_ack("init_latched", 400);
        chk("init_latched_done", 32'(init_done), 32'd1);
        step();
        chk("init_latched_ack_drop", 32'(mem_ack), 32'd0);
        chk("idx5_cleared_rvalid", 32'(lookup_rvalid), 32'd1);
        chk("idx5_cleared", lookup_rdata, 32'd0);
        lookup_addr = 8'd6;
        step();
        chk("idx6_latched_write", lookup_rdata, 32'h0000_0066);
        lookup_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
